// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared constants and round-robin pick function for rr_mux
package rr_mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    localparam int MAX_CH    = 16;
    localparam int MAX_SEL_W = 4;

    // Index of the first set bit at or after ptr, wrapping at n_ch; 0 when none set.
    function automatic logic [MAX_SEL_W-1:0] rr_pick(
        input logic [MAX_CH-1:0]    valid,
        input logic [MAX_SEL_W-1:0] ptr,
        input int                   n_ch
    );
        logic [MAX_SEL_W-1:0] idx;
        logic                 found;
        int                   c;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_CH; k++) begin
            c = int'(ptr) + k;
            if (c >= n_ch) c = c - n_ch;
            if (k < n_ch && !found && valid[c[3:0]]) begin
                idx   = c[3:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotating-priority arbiter, pointer held by caller
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             en,
    output logic [N_CH-1:0]  gnt_onehot,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);
    import rr_mux_pkg::*;

    logic [MAX_SEL_W-1:0] pick;

    always_comb begin
        pick       = rr_pick(MAX_CH'(req), MAX_SEL_W'(ptr), N_CH);
        gnt_any    = en && (|req);
        gnt_idx    = SEL_W'(pick);
        gnt_onehot = '0;
        if (gnt_any) gnt_onehot[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/rr_mux.sv
// rtl/rr_mux.sv - N-channel arbitrating mux with one-entry registered output
module rr_mux #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic [N_CH-1:0]          in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
);
    import rr_mux_pkg::*;

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  arb_ptr;
    logic [SEL_W-1:0]  gnt_idx;
    logic [N_CH-1:0]   req;
    logic [N_CH-1:0]   gnt_onehot;
    logic              gnt_any;
    logic              load;
    logic              sel_ok;
    logic              xfer;
    logic [DATA_W-1:0] gnt_data;

    // Fixed mode reuses the arbiter by masking requests down to the selected channel.
    always_comb begin
        load   = !rst && (!out_valid || out_ready);
        sel_ok = (32'(sel) < N_CH);
        if (mode == MODE_RR) begin
            req     = in_valid;
            arb_ptr = ptr;
        end else begin
            req     = sel_ok ? (in_valid & (N_CH'(1) << sel)) : '0;
            arb_ptr = sel_ok ? sel : '0;
        end
    end

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req        (req),
        .ptr        (arb_ptr),
        .en         (1'b1),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .gnt_any    (gnt_any)
    );

    always_comb begin
        in_ready = load ? gnt_onehot : '0;
        xfer     = load && gnt_any;
        gnt_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_onehot[i]) gnt_data = in_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_ch    <= gnt_idx;
            if (mode == MODE_RR) begin
                ptr <= (32'(gnt_idx) == N_CH - 1) ? '0 : gnt_idx + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux.sv
// tb/tb_rr_mux.sv - directed self-checking bench for rr_mux
module tb_rr_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    logic        mode5;
    logic [2:0]  sel5;
    logic [4:0]  in_valid5;
    logic [39:0] in_data5;
    logic [4:0]  in_ready5;
    logic        out_valid5;
    logic [7:0]  out_data5;
    logic [2:0]  out_ch5;
    logic        out_ready5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_mux #(.N_CH(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    rr_mux #(.N_CH(5), .DATA_W(8)) dut5 (
        .clk(clk), .rst(rst), .mode(mode5), .sel(sel5),
        .in_valid(in_valid5), .in_data(in_data5), .in_ready(in_ready5),
        .out_valid(out_valid5), .out_data(out_data5), .out_ch(out_ch5),
        .out_ready(out_ready5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_pre: got %b exp 0000", in_ready); end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b exp 0", c, out_valid); end
            checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data[%0d]: got %h exp 00", c, out_data); end
            checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_ch[%0d]: got %0d exp 0", c, out_ch); end
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready[%0d]: got %b exp 0000", c, in_ready); end
        end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b exp 0001", in_ready); end
    endtask

    task automatic test_rr_sweep();
        in_valid = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid[%0d]: got %b exp 1", k, out_valid); end
            checks++; if (out_ch !== 2'(k % 4)) begin errors++; $display("FAIL sweep_ch[%0d]: got %0d exp %0d", k, out_ch, k % 4); end
            checks++; if (out_data !== 8'(8'h10 + k % 4)) begin errors++; $display("FAIL sweep_data[%0d]: got %h exp %h", k, out_data, 8'h10 + k % 4); end
        end
        checks++; if (dut.ptr !== 2'd0) begin errors++; $display("FAIL sweep_ptr: got %0d exp 0", dut.ptr); end
    endtask

    task automatic test_sparse_wrap();
        logic [1:0] exp_ch [4];
        exp_ch = '{2'd0, 2'd3, 2'd0, 2'd3};
        in_valid = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (out_ch !== exp_ch[k]) begin errors++; $display("FAIL sparse_ch[%0d]: got %0d exp %0d", k, out_ch, exp_ch[k]); end
        end
        in_valid = 4'b0100;
        tick();
        checks++; if (dut.ptr !== 2'd3) begin errors++; $display("FAIL wrap_ptr3: got %0d exp 3", dut.ptr); end
        checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL wrap_ready: got %b exp 0100", in_ready); end
        tick();
        checks++; if (out_ch !== 2'd2 || out_data !== 8'h12) begin errors++; $display("FAIL wrap_grant: got ch %0d data %h exp ch 2 data 12", out_ch, out_data); end
    endtask

    task automatic test_backpressure();
        in_valid = 4'hF; out_ready = 1'b1;
        tick();
        checks++; if (out_ch !== 2'd3 || out_data !== 8'h13) begin errors++; $display("FAIL bp_load: got ch %0d data %h exp ch 3 data 13", out_ch, out_data); end
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_now: got %b exp 0000", in_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'h13) begin errors++; $display("FAIL bp_hold[%0d]: got v %b ch %0d data %h exp v 1 ch 3 data 13", c, out_valid, out_ch, out_data); end
            checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d]: got %b exp 0000", c, in_ready); end
            checks++; if (dut.ptr !== 2'd0) begin errors++; $display("FAIL bp_ptr[%0d]: got %0d exp 0", c, dut.ptr); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_ready: got %b exp 0001", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h10) begin errors++; $display("FAIL bp_next: got v %b ch %0d data %h exp v 1 ch 0 data 10", out_valid, out_ch, out_data); end
        checks++; if (dut.ptr !== 2'd1) begin errors++; $display("FAIL bp_ptr_after: got %0d exp 1", dut.ptr); end
    endtask

    task automatic test_fixed();
        mode = 1'b1; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (in_ready !== 4'b0100) begin errors++; $display("FAIL fixed_ready[%0d]: got %b exp 0100", k, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 8'h12) begin errors++; $display("FAIL fixed_out[%0d]: got v %b ch %0d data %h exp v 1 ch 2 data 12", k, out_valid, out_ch, out_data); end
        end
        checks++; if (dut.ptr !== 2'd1) begin errors++; $display("FAIL fixed_ptr: got %0d exp 1", dut.ptr); end
        in_valid = 4'b1011;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL fixed_noreq_ready: got %b exp 0000", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || out_ch !== 2'd2 || out_data !== 8'h12) begin errors++; $display("FAIL fixed_drain: got v %b ch %0d data %h exp v 0 ch 2 data 12", out_valid, out_ch, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin errors++; $display("FAIL fixed_idle: got v %b ready %b exp v 0 ready 0000", out_valid, in_ready); end

        mode5 = 1'b1; sel5 = 3'd4; in_valid5 = 5'h1F; out_ready5 = 1'b1;
        #1;
        checks++; if (in_ready5 !== 5'b10000) begin errors++; $display("FAIL sel4_ready: got %b exp 10000", in_ready5); end
        tick();
        checks++; if (out_valid5 !== 1'b1 || out_ch5 !== 3'd4 || out_data5 !== 8'h24) begin errors++; $display("FAIL sel4_out: got v %b ch %0d data %h exp v 1 ch 4 data 24", out_valid5, out_ch5, out_data5); end
        for (int s = 5; s < 8; s++) begin
            sel5 = 3'(s);
            #1;
            checks++; if (in_ready5 !== 5'b00000) begin errors++; $display("FAIL sel_illegal_ready[%0d]: got %b exp 00000", s, in_ready5); end
            tick();
            checks++; if (out_valid5 !== 1'b0) begin errors++; $display("FAIL sel_illegal_valid[%0d]: got %b exp 0", s, out_valid5); end
        end
    endtask

    task automatic test_mid_reset();
        mode = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h11) begin errors++; $display("FAIL mid_load: got v %b ch %0d data %h exp v 1 ch 1 data 11", out_valid, out_ch, out_data); end
        out_ready = 1'b0; rst = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b exp 0000", in_ready); end
        tick();
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin errors++; $display("FAIL mid_rst_out: got v %b ch %0d data %h exp v 0 ch 0 data 00", out_valid, out_ch, out_data); end
        checks++; if (dut.ptr !== 2'd0) begin errors++; $display("FAIL mid_rst_ptr: got %0d exp 0", dut.ptr); end
        in_valid = 4'b1010; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0010) begin errors++; $display("FAIL mid_next_ready: got %b exp 0010", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h11) begin errors++; $display("FAIL mid_next_out: got v %b ch %0d data %h exp v 1 ch 1 data 11", out_valid, out_ch, out_data); end
    endtask

    initial begin
        in_data    = {8'h13, 8'h12, 8'h11, 8'h10};
        in_data5   = {8'h24, 8'h23, 8'h22, 8'h21, 8'h20};
        mode5      = 1'b1;
        sel5       = 3'd0;
        in_valid5  = 5'h00;
        out_ready5 = 1'b1;
        test_reset();
        test_rr_sweep();
        test_sparse_wrap();
        test_backpressure();
        test_fixed();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
